// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : drain-FSM state encoding and default sizing shared by uart_txq.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } txq_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_txq_fifo.sv
`default_nettype none
// ============================================================================
// uart_txq_fifo : byte FIFO with occupancy count; a push is still accepted
//                 when full if a pop happens in the same cycle.
// Revision      : 1.0
// ============================================================================
module uart_txq_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_req,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic                   push_drop,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          pop_ok;
  logic          push_ok;

  assign full     = (level_q == FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok    = pop && !empty;
    push_ok   = push_req && (!full || pop_ok);
    push_drop = push_req && !push_ok;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_txq.sv
`default_nettype none
// ============================================================================
// uart_txq : byte queue draining into a UART serializer through a four-state
//            handshake FSM. Define UART_TXQ_OVF_COUNT_EN to add ovf_count.
// Revision : 1.0
// ============================================================================
module uart_txq
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
`ifdef UART_TXQ_OVF_COUNT_EN
  output logic                   overflow,
  output logic [7:0]             ovf_count
`else
  output logic                   overflow
`endif
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  txq_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_drop;
  logic [7:0]    head_data;

  uart_txq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (push_drop),
    .level     (level)
  );

  assign wr_ready = !fifo_full;
  assign tx_send  = (state_q == ST_SEND);
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q | push_drop;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // head is captured here so tx_data is already valid during SEND
        if (!fifo_empty && tx_ready) begin
          state_d   = ST_SEND;
          tx_data_d = head_data;
        end
      end
      ST_SEND: begin
        pop     = 1'b1;
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_ready || timer_q == TIMER_LAST) state_d = ST_WAIT_DONE;
        else                                    timer_d = timer_q + TW'(1);
      end
      ST_WAIT_DONE: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_TXQ_OVF_COUNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;

  assign ovf_count = ovf_count_q;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (push_drop && ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_count_q <= '0;
    else     ovf_count_q <= ovf_count_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_txq.sv
`default_nettype none
// ============================================================================
// tb_uart_txq : scenario tasks against a queue-based reference of uart_txq.
// Revision    : 1.0
// ============================================================================
module tb_uart_txq;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 8;
  localparam int LW           = $clog2(DEPTH) + 1;
  localparam int SEND_PERIOD  = BUSY_TIMEOUT + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic [LW-1:0] level;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready = 1'b1;
  logic          overflow;
`ifdef UART_TXQ_OVF_COUNT_EN
  logic [7:0]    ovf_count;
`endif

  uart_txq #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .level     (level),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_ready  (tx_ready),
`ifdef UART_TXQ_OVF_COUNT_EN
    .overflow  (overflow),
    .ovf_count (ovf_count)
`else
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  bit         ser_auto    = 1'b0;
  int         busy_cnt    = 0;
  logic [7:0] rx_q[$];
  int         send_cyc[$];

  // One clock: sample outputs 1ns after the edge, log sends, emulate serializer.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_send === 1'b1) begin
      rx_q.push_back(tx_data);
      send_cyc.push_back(cyc);
      if (ser_auto) busy_cnt = $urandom_range(4, 0);
    end
    if (ser_auto) begin
      if (busy_cnt > 0) begin
        tx_ready = 1'b0;
        busy_cnt--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    ser_auto = 1'b0; busy_cnt = 0; tx_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    rx_q.delete();
    send_cyc.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = (rx_q.size() >= n);
    for (int t = 0; t < budget && !ok; t++) begin
      step();
      ok = (rx_q.size() >= n);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (i < rx_q.size()) v = rx_q[i];
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    if (level !== LW'(0)) begin miscompares++; $display("FAIL reset_level got=%0d exp=0", level); end
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    vectors++;
    if (tx_send !== 1'b0) begin miscompares++; $display("FAIL reset_tx_send got=%b exp=0", tx_send); end
    vectors++;
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vectors++;
`ifdef UART_TXQ_OVF_COUNT_EN
    if (ovf_count !== 8'd0) begin miscompares++; $display("FAIL reset_ovf_count got=%0d exp=0", ovf_count); end
    vectors++;
`endif
  endtask

  task automatic test_latency();
    ser_auto = 1'b1; tx_ready = 1'b1;
    push_byte(8'h41);
    if (level !== LW'(1)) begin miscompares++; $display("FAIL lat_level1 got=%0d exp=1", level); end
    vectors++;
    if (tx_send !== 1'b0) begin miscompares++; $display("FAIL lat_early_send got=%b exp=0", tx_send); end
    vectors++;
    step();
    if (tx_send !== 1'b1) begin miscompares++; $display("FAIL lat_send got=%b exp=1", tx_send); end
    vectors++;
    if (tx_data !== 8'h41) begin miscompares++; $display("FAIL lat_data got=%h exp=41", tx_data); end
    vectors++;
    step();
    if (tx_send !== 1'b0) begin miscompares++; $display("FAIL lat_pulse_width got=%b exp=0", tx_send); end
    vectors++;
    if (tx_data !== 8'h41) begin miscompares++; $display("FAIL lat_data_hold got=%h exp=41", tx_data); end
    vectors++;
    repeat (20) step();
    if (level !== LW'(0)) begin miscompares++; $display("FAIL lat_level0 got=%0d exp=0", level); end
    vectors++;
    if (rx_q.size() != 1) begin miscompares++; $display("FAIL lat_send_count got=%0d exp=1", rx_q.size()); end
    vectors++;
  endtask

  task automatic test_fill_overflow();
    bit ok;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
    if (level !== LW'(DEPTH)) begin miscompares++; $display("FAIL fill_level got=%0d exp=%0d", level, DEPTH); end
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_overflow_early got=%b exp=0", overflow); end
    vectors++;
    push_byte(8'hFF);
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_overflow got=%b exp=1", overflow); end
    vectors++;
    if (level !== LW'(DEPTH)) begin miscompares++; $display("FAIL drop_level got=%0d exp=%0d", level, DEPTH); end
    vectors++;
`ifdef UART_TXQ_OVF_COUNT_EN
    if (ovf_count !== 8'd1) begin miscompares++; $display("FAIL drop_ovf_count got=%0d exp=1", ovf_count); end
    vectors++;
`endif
    ser_auto = 1'b1;
    wait_rx(DEPTH, 1000, ok);
    if (!ok) begin miscompares++; $display("FAIL fill_drain_timeout got=%0d exp=%0d", rx_q.size(), DEPTH); end
    vectors++;
    for (int i = 0; i < DEPTH; i++) begin
      if (rx_at(i) !== 8'(8'h10 + i)) begin
        miscompares++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, rx_at(i), 8'(8'h10 + i));
      end
      vectors++;
    end
    repeat (30) step();
    if (rx_q.size() != DEPTH) begin miscompares++; $display("FAIL fill_total got=%0d exp=%0d", rx_q.size(), DEPTH); end
    vectors++;
    if (level !== LW'(0)) begin miscompares++; $display("FAIL fill_final_level got=%0d exp=0", level); end
    vectors++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit found;
    bit ok;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      push_byte(b);
      exp_q.push_back(b);
    end
    tx_ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      step();
      found = (tx_send === 1'b1);
    end
    if (!found) begin miscompares++; $display("FAIL fpp_no_send got=0 exp=1"); end
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fpp_wr_ready got=%b exp=0", wr_ready); end
    vectors++;
    push_byte(8'h55);
    exp_q.push_back(8'h55);
    if (level !== LW'(DEPTH)) begin miscompares++; $display("FAIL fpp_level got=%0d exp=%0d", level, DEPTH); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    vectors++;
    ser_auto = 1'b1;
    wait_rx(exp_q.size(), 1500, ok);
    if (!ok) begin miscompares++; $display("FAIL fpp_drain_timeout got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    vectors++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_at(i) !== exp_q[i]) begin
        miscompares++; $display("FAIL fpp_order[%0d] got=%h exp=%h", i, rx_at(i), exp_q[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[3];
    int k;
    bit ok;
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    k = cyc;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = b[i];
      step();
    end
    wr_en = 1'b0;
    wait_rx(3, 200, ok);
    if (!ok) begin miscompares++; $display("FAIL tmo_sends got=%0d exp=3", rx_q.size()); end
    vectors++;
    for (int i = 0; i < 3; i++) begin
      if (i < send_cyc.size() && send_cyc[i] != k + 2 + i * SEND_PERIOD) begin
        miscompares++;
        $display("FAIL tmo_cycle[%0d] got=%0d exp=%0d", i, send_cyc[i] - k, 2 + i * SEND_PERIOD);
      end
      vectors++;
      if (rx_at(i) !== b[i]) begin miscompares++; $display("FAIL tmo_data[%0d] got=%h exp=%h", i, rx_at(i), b[i]); end
      vectors++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    tx_ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      step();
      found = (tx_send === 1'b1);
    end
    tx_ready = 1'b0;
    if (!found) begin miscompares++; $display("FAIL rmid_no_send got=0 exp=1"); end
    vectors++;
    repeat (4) step();
    if (level !== LW'(5)) begin miscompares++; $display("FAIL rmid_queued got=%0d exp=5", level); end
    vectors++;
    n = rx_q.size();
    rst = 1'b1;
    step();
    if (level !== LW'(0)) begin miscompares++; $display("FAIL rmid_level got=%0d exp=0", level); end
    vectors++;
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (40) step();
    if (rx_q.size() != n) begin miscompares++; $display("FAIL rmid_extra_send got=%0d exp=%0d", rx_q.size(), n); end
    vectors++;
    if (level !== LW'(0)) begin miscompares++; $display("FAIL rmid_level_after got=%0d exp=0", level); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
    vectors++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] model_q[$];
    int exp_level;
    bit exp_ovf;
    bit ok;
    do_reset();
    ser_auto = 1'b1;
    exp_level = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit pop_now;
      bit req;
      pop_now = (tx_send === 1'b1);
      req = ($urandom_range(99, 0) < ((i < 200) ? 50 : 10));
      wr_en = req;
      wr_data = 8'($urandom);
      if (req && (exp_level < DEPTH || pop_now)) begin
        model_q.push_back(wr_data);
        exp_level++;
      end else if (req) begin
        exp_ovf = 1'b1;
      end
      if (pop_now) exp_level--;
      step();
      if (level !== LW'(exp_level)) begin miscompares++; $display("FAIL b2b_level cyc=%0d got=%0d exp=%0d", i, level, exp_level); end
      vectors++;
      if (wr_ready !== (exp_level < DEPTH)) begin miscompares++; $display("FAIL b2b_wr_ready cyc=%0d got=%b exp=%b", i, wr_ready, exp_level < DEPTH); end
      vectors++;
      if (overflow !== exp_ovf) begin miscompares++; $display("FAIL b2b_overflow cyc=%0d got=%b exp=%b", i, overflow, exp_ovf); end
      vectors++;
    end
    wr_en = 1'b0;
    wait_rx(model_q.size(), 4000, ok);
    if (!ok) begin miscompares++; $display("FAIL b2b_drain_timeout got=%0d exp=%0d", rx_q.size(), model_q.size()); end
    vectors++;
    repeat (30) step();
    if (rx_q.size() != model_q.size()) begin miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), model_q.size()); end
    vectors++;
    for (int i = 0; i < model_q.size(); i++) begin
      if (rx_at(i) !== model_q[i]) begin
        miscompares++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, rx_at(i), model_q[i]);
      end
      vectors++;
    end
  endtask

`ifdef UART_TXQ_OVF_COUNT_EN
  task automatic test_ovf_count();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    wr_en = 1'b1;
    wr_data = 8'hEE;
    repeat (300) step();
    wr_en = 1'b0;
    if (ovf_count !== 8'd255) begin miscompares++; $display("FAIL ovf_saturate got=%0d exp=255", ovf_count); end
    vectors++;
    if (level !== LW'(DEPTH)) begin miscompares++; $display("FAIL ovf_level got=%0d exp=%0d", level, DEPTH); end
    vectors++;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_TXQ_OVF_COUNT_EN
    test_ovf_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
